// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Lock supervisor and reset sequencer for the FFT-path PLL, clocked by the
// PLL reference clock. It pulses the PLL reset, waits for a stable lock and
// only then releases the downstream reset. A lock timeout is retried a
// bounded number of times before the block parks in a sticky FAIL state.
// A lock loss while running restarts the whole sequence and is counted.
//
// Ports:
//   clk           in   reference clock (same net as the PLL input clock)
//   rst           in   synchronous reset, active-high
//   pll_lock      in   PLL lock indication, asynchronous to clk
//   pll_rst       out  reset to the PLL, active-high
//   sys_rst_out   out  reset for PLL-clocked logic, active-high
//   locked        out  high only while running with a qualified lock
//   fail          out  sticky: lock never achieved within MAX_RETRY attempts
//   lock_loss_cnt out  saturating count of lock losses seen while running
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_out,
  output logic       locked,
  output logic       fail,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_ALL = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;
  localparam int unsigned SYNC_W  = 2;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
  localparam logic [LOSS_W-1:0]  LOSS_MAX     = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic [RETRY_W-1:0]  retry_inc;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic [SYNC_W-1:0]   sync_q, sync_d;
  logic                lock_s;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;

  // Next state, counters and registered outputs
  always_comb begin
    sync_d      = {sync_q[0], pll_lock};
    lock_s      = sync_q[SYNC_W-1];
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    retry_inc   = retry_cnt_q + RETRY_W'(1);

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins over the retry.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_cnt_d = retry_inc;
          state_d     = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        // A dropout restarts the timeout window without costing a retry.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = S_RUN;
          retry_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RESET_PLL;
          if (loss_cnt_q != LOSS_MAX) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase

    // Counter clears on any state entry and only runs in timed states
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they move with the state register
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    locked_d  = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_out   = sys_rst_q;
  assign locked        = locked_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed timing scenarios with absolute
// cycle expectations plus a randomized lock waveform checked against a
// phase/duration reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned PRC = 4;
  localparam int unsigned LTO = 20;
  localparam int unsigned LSC = 8;
  localparam int unsigned MR  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst_out;
  logic       locked;
  logic       fail;
  logic [7:0] lock_loss_cnt;

  int n_cmp;
  int n_err;

  // Reference model: current phase, time spent in it, retries, losses and
  // the last two sampled lock values (index 0 newest).
  int   m_ph;
  int   m_t;
  int   m_retry;
  int   m_loss;
  logic m_hist [2];

  pll_lock_supervisor #(
    .PLL_RST_CYC      (PRC),
    .LOCK_TIMEOUT_CYC (LTO),
    .LOCK_STABLE_CYC  (LSC),
    .MAX_RETRY        (MR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .pll_rst       (pll_rst),
    .sys_rst_out   (sys_rst_out),
    .locked        (locked),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int phase_len(input int ph);
    case (ph)
      P_RST:   return int'(PRC);
      P_WAIT:  return int'(LTO);
      P_STAB:  return int'(LSC);
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags();
    return {(m_ph == P_RST) || (m_ph == P_FAIL), m_ph != P_RUN, m_ph == P_RUN, m_ph == P_FAIL};
  endfunction

  task automatic model_go(input int ph);
    m_ph = ph;
    m_t  = 0;
  endtask

  task automatic model_step(input logic lk, input logic r);
    logic ls;
    bit   expired;
    if (r) begin
      model_go(P_RST);
      m_retry   = 0;
      m_loss    = 0;
      m_hist[0] = 1'b0;
      m_hist[1] = 1'b0;
    end else begin
      ls      = m_hist[1];
      expired = (m_t + 1 >= phase_len(m_ph));
      m_t     = m_t + 1;
      if (m_ph == P_RST) begin
        if (expired) model_go(P_WAIT);
      end else if (m_ph == P_WAIT) begin
        if (ls) model_go(P_STAB);
        else if (expired) begin
          m_retry = m_retry + 1;
          model_go((m_retry == int'(MR)) ? P_FAIL : P_RST);
        end
      end else if (m_ph == P_STAB) begin
        if (!ls) model_go(P_WAIT);
        else if (expired) begin
          m_retry = 0;
          model_go(P_RUN);
        end
      end else if (m_ph == P_RUN) begin
        if (!ls) begin
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          model_go(P_RST);
        end
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = lk;
    end
  endtask

  // One clock: capture the inputs the edge will sample, advance, settle.
  task automatic tick();
    logic lk;
    logic r;
    lk = pll_lock;
    r  = rst;
    @(posedge clk);
    #1;
    model_step(lk, r);
  endtask

  task automatic do_reset(input logic lk);
    pll_lock = lk;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    pll_lock = 1'b0;
    rst      = 1'b1;
    tick();
    got = {pll_rst, sys_rst_out, locked, fail};
    n_cmp++;
    if (got !== 4'b1100 || lock_loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_held flags=%b loss=%0d expected flags=1100 loss=0", got, lock_loss_cnt);
    end
    tick();
    rst = 1'b0;
    got = {pll_rst, sys_rst_out, locked, fail};
    n_cmp++;
    if (got !== 4'b1100 || lock_loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_cycle0 flags=%b loss=%0d expected flags=1100 loss=0", got, lock_loss_cnt);
    end
  endtask

  task automatic test_normal_lock();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset(1'b1);
    for (int c = 0; c <= 20; c++) begin
      got = {pll_rst, sys_rst_out, locked, fail};
      exp = {c <= 3, c < 13, c >= 13, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL normal_lock c=%0d flags=%b expected %b", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_timeout_fail();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset(1'b0);
    for (int c = 0; c <= 60; c++) begin
      got = {pll_rst, sys_rst_out, locked, fail};
      exp = {(c <= 3) || (c >= 24 && c <= 27) || (c >= 48), 1'b1, 1'b0, c >= 48};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL timeout_fail c=%0d flags=%b expected %b", c, got, exp);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {pll_rst, sys_rst_out, locked, fail};
    n_cmp++;
    if (got !== 4'b1100) begin
      n_err++;
      $display("FAIL fail_cleared_by_rst flags=%b expected 1100", got);
    end
  endtask

  task automatic test_stable_glitch();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset(1'b1);
    for (int c = 0; c <= 25; c++) begin
      got = {pll_rst, sys_rst_out, locked, fail};
      exp = {c <= 3, c < 20, c >= 20, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stable_glitch c=%0d flags=%b expected %b", c, got, exp);
      end
      // Edge 8 samples a low lock, seen internally during STABLE cnt=5.
      pll_lock = (c != 8);
      tick();
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] got;
    logic [3:0] exp;
    logic [7:0] exp_loss;
    bit         run;
    do_reset(1'b1);
    for (int c = 0; c <= 35; c++) begin
      run      = (c >= 13 && c <= 17) || (c >= 31);
      got      = {pll_rst, sys_rst_out, locked, fail};
      exp      = {(c <= 3) || (c >= 18 && c <= 21), !run, run, 1'b0};
      exp_loss = (c >= 18) ? 8'd1 : 8'd0;
      n_cmp++;
      if (got !== exp || lock_loss_cnt !== exp_loss) begin
        n_err++;
        $display("FAIL lock_loss c=%0d flags=%b loss=%0d expected %b loss=%0d",
                 c, got, lock_loss_cnt, exp, exp_loss);
      end
      pll_lock = !(c >= 15 && c < 18);
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_loss;
    bit         ok;
    do_reset(1'b1);
    for (int k = 1; k <= 260; k++) begin
      for (int i = 0; i < 100 && !locked; i++) tick();
      ok = locked;
      if (ok) begin
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int i = 0; i < 10 && locked; i++) tick();
        ok = !locked;
      end
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL saturation_timeout event=%0d locked=%b expected a lock transition", k, locked);
        break;
      end
      exp_loss = (k > 255) ? 8'd255 : 8'(k);
      n_cmp++;
      if (lock_loss_cnt !== exp_loss) begin
        n_err++;
        $display("FAIL saturation event=%0d loss=%0d expected %0d", k, lock_loss_cnt, exp_loss);
      end
    end
  endtask

  task automatic test_rst_in_run();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 100 && !locked; i++) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      for (int i = 0; i < 10 && locked; i++) tick();
    end
    for (int i = 0; i < 100 && !locked; i++) tick();
    n_cmp++;
    if (locked !== 1'b1 || lock_loss_cnt !== 8'd3) begin
      n_err++;
      $display("FAIL rst_run_setup locked=%b loss=%0d expected locked=1 loss=3", locked, lock_loss_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {pll_rst, sys_rst_out, locked, fail};
    n_cmp++;
    if (got !== 4'b1100 || lock_loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL rst_in_run flags=%b loss=%0d expected flags=1100 loss=0", got, lock_loss_cnt);
    end
    for (int c = 0; c <= 16; c++) begin
      got = {pll_rst, sys_rst_out, locked, fail};
      exp = {c <= 3, c < 13, c >= 13, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rst_replay c=%0d flags=%b expected %b", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [11:0] got;
    logic [11:0] exp;
    int          cyc;
    int          len;
    logic        lvl;
    do_reset(1'b1);
    cyc = 0;
    while (cyc < 4000) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        len = 1;
      end else begin
        lvl = ($urandom_range(0, 9) < 6);
        len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 60));
        pll_lock = lvl;
      end
      for (int i = 0; i < len; i++) begin
        tick();
        rst = 1'b0;
        cyc++;
        got = {pll_rst, sys_rst_out, locked, fail, lock_loss_cnt};
        exp = {m_flags(), 8'(m_loss)};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL random cyc=%0d flags_loss=%b expected %b", cyc, got, exp);
        end
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    model_go(P_RST);
    m_retry   = 0;
    m_loss    = 0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
    test_reset();
    test_normal_lock();
    test_timeout_fail();
    test_stable_glitch();
    test_lock_loss();
    test_saturation();
    test_rst_in_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
